// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU and loader, one access per accept/access/response sequence.
// Define ARB_RR_EN for round-robin arbitration; otherwise the loader has fixed priority over the CPU.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_we,
    input  logic              c_req_inst,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic [DATA_W-1:0] c_req_wdata,
    output logic              c_rsp_valid,
    output logic [DATA_W-1:0] c_rsp_rdata,
    input  logic              l_req_valid,
    output logic              l_req_ready,
    input  logic              l_req_we,
    input  logic              l_req_inst,
    input  logic [ADDR_W-1:0] l_req_addr,
    input  logic [DATA_W-1:0] l_req_wdata,
    output logic              l_rsp_valid,
    output logic [DATA_W-1:0] l_rsp_rdata,
    input  logic              l_lock,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              memRead,
    output logic              memWrite,
    output logic              IRWrite,
    input  logic [DATA_W-1:0] mem_readData,
    input  logic [DATA_W-1:0] mem_readInst
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, nxt;
    logic we_q, inst_q, gid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rsp_q;
    logic ce, le, gc, gl, go, i_st, a_st, r_st;

    assign ce = c_req_valid & ~l_lock;
    assign le = l_req_valid;
`ifdef ARB_RR_EN
    logic ptr_q;
    assign gl = le & (~ce | ptr_q);
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else if (go) ptr_q <= gc;
    end
`else
    assign gl = le;
`endif
    assign gc = ce & ~gl;
    // Outputs are gated by rst so an in-flight write never reaches the memory edge during reset.
    assign i_st = (state == IDLE) & ~rst;
    assign a_st = (state == ACCESS) & ~rst;
    assign r_st = (state == RESP) & ~rst;
    assign go = i_st & (gc | gl);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = (state == IDLE) ? (go ? ACCESS : IDLE) : (state == ACCESS) ? RESP : IDLE;
    end

    always_comb begin
        c_req_ready = i_st & gc;
        l_req_ready = i_st & gl;
        memRead = a_st & ~we_q & ~inst_q;
        memWrite = a_st & we_q;
        IRWrite = a_st & inst_q;
        mem_address = a_st ? addr_q : '0;
        mem_writeData = a_st ? wdata_q : '0;
        c_rsp_valid = r_st & ~gid_q;
        l_rsp_valid = r_st & gid_q;
        c_rsp_rdata = (r_st & ~gid_q) ? rsp_q : '0;
        l_rsp_rdata = (r_st & gid_q) ? rsp_q : '0;
    end

    // A write with inst also set is treated as a plain data write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            inst_q <= 1'b0;
            gid_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rsp_q <= '0;
        end else begin
            if (go) begin
                we_q <= gl ? l_req_we : c_req_we;
                inst_q <= gl ? (l_req_inst & ~l_req_we) : (c_req_inst & ~c_req_we);
                gid_q <= gl;
                addr_q <= gl ? l_req_addr : c_req_addr;
                wdata_q <= gl ? l_req_wdata : c_req_wdata;
            end
            if (a_st) rsp_q <= inst_q ? mem_readInst : we_q ? '0 : mem_readData;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios against a behavioural unified memory (fetch word = 256 + byte_addr/4).
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c_req_valid = 1'b0, c_req_we = 1'b0, c_req_inst = 1'b0;
    logic [31:0] c_req_addr = '0, c_req_wdata = '0;
    logic l_req_valid = 1'b0, l_req_we = 1'b0, l_req_inst = 1'b0, l_lock = 1'b0;
    logic [31:0] l_req_addr = '0, l_req_wdata = '0;
    logic c_req_ready, c_rsp_valid, l_req_ready, l_rsp_valid;
    logic [31:0] c_rsp_rdata, l_rsp_rdata, mem_address, mem_writeData, mem_readData, mem_readInst;
    logic memRead, memWrite, IRWrite;
    logic [31:0] mem [0:511];
    logic [31:0] iaddr;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
        .c_req_inst(c_req_inst), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_we(l_req_we),
        .l_req_inst(l_req_inst), .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
        .l_rsp_valid(l_rsp_valid), .l_rsp_rdata(l_rsp_rdata), .l_lock(l_lock),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
        .mem_readData(mem_readData), .mem_readInst(mem_readInst)
    );

    assign iaddr = 32'd256 + (mem_address >> 2);
    assign mem_readData = mem[mem_address[8:0]];
    assign mem_readInst = mem[iaddr[8:0]];
    always @(posedge clk) if (memWrite) mem[mem_address[8:0]] <= mem_writeData;

    task automatic creq(input logic we, input logic inst, input logic [31:0] addr, input logic [31:0] wd);
        c_req_valid = 1'b1; c_req_we = we; c_req_inst = inst; c_req_addr = addr; c_req_wdata = wd;
    endtask

    task automatic lreq(input logic we, input logic inst, input logic [31:0] addr, input logic [31:0] wd);
        l_req_valid = 1'b1; l_req_we = we; l_req_inst = inst; l_req_addr = addr; l_req_wdata = wd;
    endtask

    task automatic clr();
        c_req_valid = 1'b0; l_req_valid = 1'b0;
        c_req_addr = 32'hdead_beef; l_req_addr = 32'hdead_beef;
        c_req_wdata = 32'hffff_ffff; l_req_wdata = 32'hffff_ffff;
    endtask

    task automatic test_reset();
        logic [8:0] v;
        rst = 1'b1;
        @(negedge clk);
        v = {c_req_ready, l_req_ready, c_rsp_valid, l_rsp_valid, memRead, memWrite, IRWrite, |c_rsp_rdata, |l_rsp_rdata};
        total++; if (v !== 9'b0) begin bad++; $display("FAIL reset_during ctl got=%b exp=0", v); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        v = {c_req_ready, l_req_ready, c_rsp_valid, l_rsp_valid, memRead, memWrite, IRWrite, |mem_address, |mem_writeData};
        total++; if (v !== 9'b0) begin bad++; $display("FAIL reset_after ctl got=%b exp=0", v); end
    endtask

    task automatic test_fetch();
        @(posedge clk); #1 creq(1'b0, 1'b1, 32'd0, 32'd0);
        @(negedge clk);
        total++; if (c_req_ready !== 1'b1) begin bad++; $display("FAIL fetch_ready got=%b exp=1", c_req_ready); end
        @(posedge clk); #1 clr();
        @(negedge clk);
        total++; if ({IRWrite, memRead, memWrite} !== 3'b100 || mem_address !== 32'd0)
            begin bad++; $display("FAIL fetch_strobe got=%b addr=%h exp=100 addr=0", {IRWrite, memRead, memWrite}, mem_address); end
        @(posedge clk); @(negedge clk);
        total++; if (c_rsp_valid !== 1'b1 || c_rsp_rdata !== 32'h2007000F)
            begin bad++; $display("FAIL fetch_rsp got=%b/%h exp=1/2007000f", c_rsp_valid, c_rsp_rdata); end
    endtask

    task automatic test_ldr_write_cpu_read();
        @(posedge clk); #1 lreq(1'b1, 1'b0, 32'd20, 32'h0000ABCD);
        @(negedge clk);
        total++; if ({l_req_ready, c_req_ready} !== 2'b10) begin bad++; $display("FAIL lw_ready got=%b exp=10", {l_req_ready, c_req_ready}); end
        @(posedge clk); #1 clr();
        @(negedge clk);
        total++; if ({memWrite, memRead, IRWrite} !== 3'b100 || mem_address !== 32'd20 || mem_writeData !== 32'h0000ABCD)
            begin bad++; $display("FAIL lw_access got=%b %h %h exp=100 14 abcd", {memWrite, memRead, IRWrite}, mem_address, mem_writeData); end
        @(posedge clk); @(negedge clk);
        total++; if (l_rsp_valid !== 1'b1 || l_rsp_rdata !== 32'd0 || memWrite !== 1'b0 || c_rsp_valid !== 1'b0)
            begin bad++; $display("FAIL lw_rsp got=%b/%h we=%b c=%b exp=1/0 we=0 c=0", l_rsp_valid, l_rsp_rdata, memWrite, c_rsp_valid); end
        @(posedge clk); #1 creq(1'b0, 1'b0, 32'd20, 32'd0);
        @(negedge clk);
        total++; if (c_req_ready !== 1'b1) begin bad++; $display("FAIL cr_ready got=%b exp=1", c_req_ready); end
        @(posedge clk); #1 clr();
        @(negedge clk);
        total++; if ({memRead, memWrite, IRWrite} !== 3'b100) begin bad++; $display("FAIL cr_strobe got=%b exp=100", {memRead, memWrite, IRWrite}); end
        @(posedge clk); @(negedge clk);
        total++; if (c_rsp_valid !== 1'b1 || c_rsp_rdata !== 32'h0000ABCD)
            begin bad++; $display("FAIL cr_rsp got=%b/%h exp=1/0000abcd", c_rsp_valid, c_rsp_rdata); end
    endtask

    task automatic test_we_inst();
        @(posedge clk); #1 creq(1'b1, 1'b1, 32'd5, 32'd7);
        @(negedge clk);
        total++; if (c_req_ready !== 1'b1) begin bad++; $display("FAIL wi_ready got=%b exp=1", c_req_ready); end
        @(posedge clk); #1 clr();
        @(negedge clk);
        total++; if ({memWrite, IRWrite, memRead} !== 3'b100 || mem_address !== 32'd5)
            begin bad++; $display("FAIL wi_strobe got=%b addr=%h exp=100 addr=5", {memWrite, IRWrite, memRead}, mem_address); end
        @(posedge clk); @(negedge clk);
        total++; if (c_rsp_valid !== 1'b1 || c_rsp_rdata !== 32'd0) begin bad++; $display("FAIL wi_rsp got=%b/%h exp=1/0", c_rsp_valid, c_rsp_rdata); end
        @(posedge clk); #1 creq(1'b0, 1'b0, 32'd5, 32'd0);
        @(posedge clk); #1 clr();
        @(posedge clk); @(negedge clk);
        total++; if (c_rsp_rdata !== 32'd7) begin bad++; $display("FAIL wi_readback got=%h exp=7", c_rsp_rdata); end
    endtask

    task automatic test_lock();
        @(posedge clk); #1 l_lock = 1'b1; creq(1'b0, 1'b0, 32'd20, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (c_req_ready !== 1'b0) begin bad++; $display("FAIL lock_block[%0d] got=%b exp=0", i, c_req_ready); end
            @(posedge clk); #1;
        end
        l_lock = 1'b0;
        @(negedge clk);
        total++; if (c_req_ready !== 1'b1) begin bad++; $display("FAIL lock_release got=%b exp=1", c_req_ready); end
        @(posedge clk); #1 clr(); l_lock = 1'b1;
        @(negedge clk);
        total++; if (memRead !== 1'b1) begin bad++; $display("FAIL lock_mid_access got=%b exp=1", memRead); end
        @(posedge clk); @(negedge clk);
        total++; if (c_rsp_valid !== 1'b1 || c_rsp_rdata !== 32'h0000ABCD)
            begin bad++; $display("FAIL lock_mid_rsp got=%b/%h exp=1/0000abcd", c_rsp_valid, c_rsp_rdata); end
        l_lock = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [6:0] v;
        @(posedge clk); #1 creq(1'b1, 1'b0, 32'd30, 32'h55);
        @(negedge clk);
        total++; if (c_req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", c_req_ready); end
        @(posedge clk); #1 clr(); rst = 1'b1;
        @(negedge clk);
        v = {memWrite, memRead, IRWrite, c_rsp_valid, l_rsp_valid, |mem_address, |mem_writeData};
        total++; if (v !== 7'b0) begin bad++; $display("FAIL abort_in_reset got=%b exp=0", v); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        v = {memWrite, memRead, IRWrite, c_rsp_valid, l_rsp_valid, |c_rsp_rdata, |mem_address};
        total++; if (v !== 7'b0) begin bad++; $display("FAIL abort_after got=%b exp=0", v); end
        total++; if (mem[30] !== 32'h1234) begin bad++; $display("FAIL abort_word got=%h exp=1234", mem[30]); end
        @(posedge clk); #1 creq(1'b0, 1'b0, 32'd30, 32'd0);
        @(negedge clk);
        total++; if (c_req_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b exp=1", c_req_ready); end
        @(posedge clk); #1 clr();
        @(posedge clk); @(negedge clk);
        total++; if (c_rsp_rdata !== 32'h1234) begin bad++; $display("FAIL abort_readback got=%h exp=1234", c_rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        logic ec;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        creq(1'b0, 1'b0, 32'd20, 32'd0);
        lreq(1'b0, 1'b0, 32'd5, 32'd0);
        for (int g = 0; g < 6; g++) begin
`ifdef ARB_RR_EN
            ec = (g % 2) == 0;
`else
            ec = 1'b0;
`endif
            @(negedge clk);
            total++; if ({c_req_ready, l_req_ready} !== {ec, ~ec})
                begin bad++; $display("FAIL arb_grant[%0d] got=%b exp=%b", g, {c_req_ready, l_req_ready}, {ec, ~ec}); end
            @(posedge clk); @(posedge clk); @(negedge clk);
            total++; if ({c_req_ready, l_req_ready, c_rsp_valid, l_rsp_valid} !== {2'b00, ec, ~ec})
                begin bad++; $display("FAIL arb_rsp[%0d] got=%b exp=%b", g, {c_req_ready, l_req_ready, c_rsp_valid, l_rsp_valid}, {2'b00, ec, ~ec}); end
            if (g < 5) @(posedge clk);
        end
        clr();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[256] = 32'h2007000F;
        mem[30] = 32'h1234;
        clr();
        test_reset();
        test_fetch();
        test_ldr_write_cpu_read();
        test_we_inst();
        test_lock();
        test_reset_abort();
        test_back_to_back();
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
